// File: rtl/detector_pkg.sv
// Shared definitions for the detector power-up sequencer: state encoding and counter widths.
package detector_pkg;
  localparam int STATE_W     = 3;
  localparam int CNT_W       = 24;
  localparam int MAX_RETRIES = 3;

  localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] S_RST_HOLD = 3'd1;
  localparam logic [STATE_W-1:0] S_WAKE     = 3'd2;
  localparam logic [STATE_W-1:0] S_SETTLE   = 3'd3;
  localparam logic [STATE_W-1:0] S_RUN      = 3'd4;
  localparam logic [STATE_W-1:0] S_FAULT    = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = S_IDLE,
    ST_RST_HOLD = S_RST_HOLD,
    ST_WAKE     = S_WAKE,
    ST_SETTLE   = S_SETTLE,
    ST_RUN      = S_RUN,
    ST_FAULT    = S_FAULT
  } state_e;
endpackage

// File: rtl/detector_edge_sync.sv
// Two-flop synchronizer for the detector vsync plus a registered rising-edge pulse
// (pulse is high in the third clk cycle after the input rises).
module detector_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_async,
  output logic vsync_rise
);
  // [0],[1] synchronizer, [2] previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vsync_rise <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], vsync_async};
      vsync_rise <= sync_q[1] & ~sync_q[2];
    end
  end
endmodule

// File: rtl/detector_seq_ctrl.sv
// Detector power-up sequencer: reset pulse, wake, vsync settle, run with vsync watchdog.
// Optional DETSEQ_AUTO_RETRY_EN: FAULT retries the reset sequence up to MAX_RETRIES times.
module detector_seq_ctrl
  import detector_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 1000,
  parameter int SETTLE_FRAMES   = 4,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cfg_i2cad,
  input  logic               dd_vsync,
  input  logic               err_clr,
  output logic               dd_nrst,
  output logic               dd_i2cad,
  output logic               output_select,
  output logic [STATE_W-1:0] state_o,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic               err_timeout
);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_FRAMES - 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       settle_cnt;
  logic             vs_edge, timed, timeout, start_ok, auto_retry, fault_timed, cnt_run;
  logic             nrst_nx, osel_nx, busy_nx;

  detector_edge_sync u_edge_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_async (dd_vsync),
    .vsync_rise  (vs_edge)
  );

  assign timed    = (state == ST_WAKE) || (state == ST_SETTLE) || (state == ST_RUN);
  assign timeout  = timed && !vs_edge && (cnt == TO_LAST);
  assign start_ok = cmd_start && !cmd_stop && ((state == ST_IDLE) || (state == ST_FAULT));
  assign cnt_run  = timed || (state == ST_RST_HOLD) || fault_timed;
  assign state_o  = state;

`ifdef DETSEQ_AUTO_RETRY_EN
  logic [1:0] retry_cnt;

  // FAULT reuses the cycle counter as a hold timer while retries remain
  assign fault_timed = (state == ST_FAULT) && (retry_cnt < 2'(MAX_RETRIES));
  assign auto_retry  = fault_timed && (cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retry_cnt <= '0;
    else if (start_ok || state_nx == ST_RUN || state_nx == ST_IDLE)
      retry_cnt <= '0;
    else if (auto_retry && state_nx == ST_RST_HOLD)
      retry_cnt <= retry_cnt + 2'd1;
  end
`else
  assign fault_timed = 1'b0;
  assign auto_retry  = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (cmd_start) state_nx = ST_RST_HOLD;
      ST_RST_HOLD: if (cnt == HOLD_LAST) state_nx = ST_WAKE;
      ST_WAKE:     if (vs_edge) state_nx = ST_SETTLE;
                   else if (timeout) state_nx = ST_FAULT;
      // The edge that left WAKE counts as the first settle frame
      ST_SETTLE:   if (vs_edge && settle_cnt >= SETTLE_LAST) state_nx = ST_RUN;
                   else if (timeout) state_nx = ST_FAULT;
      ST_RUN:      if (timeout) state_nx = ST_FAULT;
      ST_FAULT:    if (cmd_start || auto_retry) state_nx = ST_RST_HOLD;
      default:     state_nx = ST_IDLE;
    endcase
    if (cmd_stop) state_nx = ST_IDLE;

    nrst_nx = (state_nx == ST_WAKE) || (state_nx == ST_SETTLE) || (state_nx == ST_RUN);
    osel_nx = (state_nx == ST_RUN);
    busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dd_nrst       <= 1'b0;
      dd_i2cad      <= 1'b0;
      output_select <= 1'b0;
      busy          <= 1'b0;
      cnt           <= '0;
      settle_cnt    <= '0;
      frame_cnt     <= '0;
      err_timeout   <= 1'b0;
    end else begin
      state         <= state_nx;
      dd_nrst       <= nrst_nx;
      output_select <= osel_nx;
      busy          <= busy_nx;

      if (start_ok) dd_i2cad <= cfg_i2cad;

      if (state_nx != state || (timed && vs_edge)) cnt <= '0;
      else if (cnt_run)                            cnt <= cnt + CNT_W'(1);

      if (state == ST_WAKE && state_nx == ST_SETTLE) settle_cnt <= 8'd1;
      else if (state == ST_SETTLE && vs_edge)        settle_cnt <= settle_cnt + 8'd1;

      if (state_nx == ST_RST_HOLD && state != ST_RST_HOLD) frame_cnt <= '0;
      else if (state == ST_RUN && vs_edge)                 frame_cnt <= frame_cnt + 16'd1;

      if (state_nx == ST_FAULT && state != ST_FAULT) err_timeout <= 1'b1;
      else if (err_clr)                              err_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Directed bench for detector_seq_ctrl with short hold/settle/timeout parameters.
module tb_detector_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, cfg_i2cad = 1'b0, dd_vsync = 1'b0, err_clr = 1'b0;
  logic        dd_nrst, dd_i2cad, output_select, busy, err_timeout;
  logic [2:0]  state_o;
  logic [15:0] frame_cnt;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  detector_seq_ctrl #(
    .RST_HOLD_CYCLES (8),
    .SETTLE_FRAMES   (2),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .cfg_i2cad     (cfg_i2cad),
    .dd_vsync      (dd_vsync),
    .err_clr       (err_clr),
    .dd_nrst       (dd_nrst),
    .dd_i2cad      (dd_i2cad),
    .output_select (output_select),
    .state_o       (state_o),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .err_timeout   (err_timeout)
  );

  // Advance n clock edges and sit 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_cmp++;
    if ({state_o, dd_nrst, dd_i2cad, output_select, busy, err_timeout} !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 00", {state_o, dd_nrst, dd_i2cad, output_select, busy, err_timeout});
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
    end
    rst_n = 1'b1;
    step(3);
    n_cmp++;
    if ({state_o, busy} !== 4'b000_0) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 0000", {state_o, busy});
    end
  endtask

  task automatic test_startup();
    int bad;
    cfg_i2cad = 1'b1; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    n_cmp++;
    if ({state_o, dd_nrst, dd_i2cad, busy} !== {3'd1, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL start_latch: got %b expected 001011", {state_o, dd_nrst, dd_i2cad, busy});
    end
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (state_o !== 3'd1 || dd_nrst !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL rst_hold_len: %0d early exits, expected 0", bad);
    end
    step(1);
    n_cmp++;
    if ({state_o, dd_nrst} !== {3'd2, 1'b1}) begin
      n_err++; $display("FAIL wake_entry: got %b expected 0101", {state_o, dd_nrst});
    end
    dd_vsync = 1'b1;
    step(3);
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_err++; $display("FAIL edge_latency_early: got state %0d expected 2", state_o);
    end
    step(1);
    n_cmp++;
    if (state_o !== 3'd3) begin
      n_err++; $display("FAIL settle_entry: got state %0d expected 3", state_o);
    end
    dd_vsync = 1'b0;
    step(46);
    dd_vsync = 1'b1;
    step(4);
    dd_vsync = 1'b0;
    n_cmp++;
    if ({state_o, output_select, dd_nrst, busy} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL run_entry: got %b expected 100110", {state_o, output_select, dd_nrst, busy});
    end
    n_cmp++;
    if (frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL run_entry_frames: got %0d expected 0", frame_cnt);
    end
    step(1);
    cfg_i2cad = 1'b0; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    n_cmp++;
    if ({state_o, dd_i2cad} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL start_ignored_in_run: got %b expected 1001", {state_o, dd_i2cad});
    end
    step(44);
    for (int f = 1; f <= 3; f++) begin
      dd_vsync = 1'b1;
      step(4);
      dd_vsync = 1'b0;
      n_cmp++;
      if (frame_cnt !== 16'(f)) begin
        n_err++; $display("FAIL frame_count: got %0d expected %0d", frame_cnt, f);
      end
      if (f < 3) step(46);
    end
  endtask

  task automatic test_timeout();
    step(99);
    n_cmp++;
    if ({state_o, output_select} !== {3'd4, 1'b1}) begin
      n_err++; $display("FAIL run_before_timeout: got %b expected 1001", {state_o, output_select});
    end
    step(1);
    n_cmp++;
    if ({state_o, dd_nrst, output_select, busy, err_timeout} !== {3'd5, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL run_timeout_fault: got %b expected 1010011", {state_o, dd_nrst, output_select, busy, err_timeout});
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_cmp++;
    if ({state_o, err_timeout} !== {3'd5, 1'b0}) begin
      n_err++; $display("FAIL err_clr: got %b expected 1010", {state_o, err_timeout});
    end
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    n_cmp++;
    if ({state_o, busy} !== {3'd0, 1'b0}) begin
      n_err++; $display("FAIL stop_from_fault: got %b expected 0000", {state_o, busy});
    end
  endtask

  task automatic test_stop();
    n_cmp++;
    if (frame_cnt !== 16'd3) begin
      n_err++; $display("FAIL frame_cnt_held: got %0d expected 3", frame_cnt);
    end
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step(1);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    n_cmp++;
    if ({state_o, busy, dd_i2cad} !== {3'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL stop_wins: got %b expected 00001", {state_o, busy, dd_i2cad});
    end
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    n_cmp++;
    if ({state_o, dd_i2cad} !== {3'd1, 1'b0} || frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL restart_relatch: got state %0d i2cad %b frames %0d expected 1 0 0", state_o, dd_i2cad, frame_cnt);
    end
    step(8);
    dd_vsync = 1'b1;
    step(4);
    dd_vsync = 1'b0;
    n_cmp++;
    if (state_o !== 3'd3) begin
      n_err++; $display("FAIL settle_again: got state %0d expected 3", state_o);
    end
    step(5);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    n_cmp++;
    if ({state_o, dd_nrst, busy, output_select} !== 6'b000_000) begin
      n_err++; $display("FAIL stop_in_settle: got %b expected 000000", {state_o, dd_nrst, busy, output_select});
    end
  endtask

  task automatic test_async_reset();
    cfg_i2cad = 1'b1; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    step(8);
    dd_vsync = 1'b1;
    step(4);
    dd_vsync = 1'b0;
    n_cmp++;
    if ({state_o, dd_i2cad, dd_nrst} !== {3'd3, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL pre_reset_settle: got %b expected 01111", {state_o, dd_i2cad, dd_nrst});
    end
    step(3);
    #2;
    rst_n = 1'b0; cmd_start = 1'b1;
    #1;
    n_cmp++;
    if ({state_o, dd_nrst, dd_i2cad, output_select, busy, err_timeout} !== 8'h00 || frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL async_reset: got %h frames %0d expected 00 0", {state_o, dd_nrst, dd_i2cad, output_select, busy, err_timeout}, frame_cnt);
    end
    step(1);
    cmd_start = 1'b0; rst_n = 1'b1;
    dd_vsync = 1'b1;
    step(4);
    dd_vsync = 1'b0;
    step(20);
    n_cmp++;
    if ({state_o, dd_nrst, busy} !== 5'b000_00 || frame_cnt !== 16'd0) begin
      n_err++; $display("FAIL no_retained_cmd: got %b frames %0d expected 00000 0", {state_o, dd_nrst, busy}, frame_cnt);
    end
  endtask

  task automatic test_fault_retry();
    int holds, faults, first_fault, first_retry;
    logic [2:0] prev;
    holds = 1; faults = 0; first_fault = 0; first_retry = 0;
    cfg_i2cad = 1'b1; err_clr = 1'b1; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    prev = state_o;
    for (int cyc = 2; cyc <= 1000; cyc++) begin
      step(1);
      if (state_o == 3'd1 && prev != 3'd1) begin
        holds++;
        if (first_retry == 0) first_retry = cyc;
      end
      if (state_o == 3'd5 && prev != 3'd5) begin
        faults++;
        if (first_fault == 0) first_fault = cyc;
      end
      if (cyc == 109) begin
        n_cmp++;
        if (err_timeout !== 1'b1) begin
          n_err++; $display("FAIL fault_entry_beats_clr: got %b expected 1", err_timeout);
        end
      end
      if (cyc == 110) begin
        n_cmp++;
        if (err_timeout !== 1'b0) begin
          n_err++; $display("FAIL clr_after_entry: got %b expected 0", err_timeout);
        end
        err_clr = 1'b0;
      end
      prev = state_o;
    end
    n_cmp++;
    if (first_fault !== 109) begin
      n_err++; $display("FAIL wake_timeout_cycle: got %0d expected 109", first_fault);
    end
`ifdef DETSEQ_AUTO_RETRY_EN
    n_cmp++;
    if (holds !== 4 || faults !== 4) begin
      n_err++; $display("FAIL retry_count: got holds %0d faults %0d expected 4 4", holds, faults);
    end
    n_cmp++;
    if (first_retry !== 117) begin
      n_err++; $display("FAIL first_retry_cycle: got %0d expected 117", first_retry);
    end
`else
    n_cmp++;
    if (holds !== 1 || faults !== 1) begin
      n_err++; $display("FAIL single_fault: got holds %0d faults %0d expected 1 1", holds, faults);
    end
`endif
    n_cmp++;
    if ({state_o, dd_nrst, output_select} !== {3'd5, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL fault_held: got %b expected 10100", {state_o, dd_nrst, output_select});
    end
    cfg_i2cad = 1'b0; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    n_cmp++;
    if ({state_o, dd_i2cad} !== {3'd1, 1'b0}) begin
      n_err++; $display("FAIL start_from_fault: got %b expected 0010", {state_o, dd_i2cad});
    end
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    n_cmp++;
    if (state_o !== 3'd0) begin
      n_err++; $display("FAIL final_stop: got state %0d expected 0", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_timeout();
    test_stop();
    test_async_reset();
    test_fault_retry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/detector_seq_ctrl.md
DETECTOR_SEQ_CTRL -- requirements
Module: detector_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 1000, detector reset pulse length in clk cycles (>=1).
REQ-002 SHALL have parameter SETTLE_FRAMES, default 4, vsync edges required before video is enabled (1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles between vsync edges (< 2^24).
REQ-004 SHALL have port clk  in  1  system clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_start, cmd_stop  in  1 each  single-cycle command pulses.
REQ-007 SHALL have port cfg_i2cad  in  1  detector I2C address select to apply.
REQ-008 SHALL have port dd_vsync  in  1  detector vsync, asynchronous to clk.
REQ-009 SHALL have ports dd_nrst, dd_i2cad, output_select  out  1 each  detector reset, address pin, video/background mux select.
REQ-010 SHALL have port state_o  out  3  encoded FSM state; busy  out  1  high in any state except IDLE and RUN.
REQ-011 SHALL have port frame_cnt  out  16  vsync edges counted in RUN; err_timeout  out  1  sticky fault flag; err_clr  in  1  clears err_timeout.

Function
REQ-012 SHALL synchronize dd_vsync through 2 flops and detect rising edges; edge pulse SHALL occur 3 clk cycles after the input rises.
REQ-013 SHALL implement states IDLE=0, RST_HOLD=1, WAKE=2, SETTLE=3, RUN=4, FAULT=5; all outputs registered.
REQ-014 IDLE: dd_nrst=0, output_select=0; cmd_start -> RST_HOLD and latches cfg_i2cad into dd_i2cad.
REQ-015 RST_HOLD: dd_nrst=0 for exactly RST_HOLD_CYCLES cycles, then -> WAKE with dd_nrst=1.
REQ-016 WAKE: first vsync edge -> SETTLE; TIMEOUT_CYCLES without edge -> FAULT.
REQ-017 SETTLE: counts vsync edges; on SETTLE_FRAMES-th edge -> RUN; gap of TIMEOUT_CYCLES -> FAULT.
REQ-018 RUN: output_select=1; frame_cnt increments per edge, wraps 0xFFFF->0; timeout -> FAULT with output_select=0 in the cycle FAULT is entered.
REQ-019 FAULT: dd_nrst=0, output_select=0, err_timeout set; cmd_start -> RST_HOLD (re-latches cfg_i2cad).
REQ-020 Timeout counter SHALL restart on every vsync edge and on every state entry.
REQ-021 cmd_stop SHALL force IDLE from any state next cycle; cmd_stop and cmd_start together: stop wins.
REQ-022 cmd_start in RST_HOLD/WAKE/SETTLE/RUN SHALL be ignored; dd_i2cad SHALL not change outside IDLE/FAULT exits.
REQ-023 frame_cnt SHALL clear on entry to RST_HOLD; err_clr SHALL clear err_timeout, but FAULT entry in the same cycle wins.

Reset
REQ-024 On rst_n low: state IDLE, dd_nrst=0, dd_i2cad=0, output_select=0, frame_cnt=0, err_timeout=0, synchronizer flops=0, all counters=0.
REQ-025 Reset mid-sequence SHALL abort immediately; no command SHALL be retained.

Configuration
REQ-026 With DETSEQ_AUTO_RETRY_EN defined, FAULT SHALL re-enter RST_HOLD automatically after RST_HOLD_CYCLES, up to 3 retries; retry count clears on reaching RUN; after the 3rd failure FAULT waits for cmd_start.
REQ-027 Without DETSEQ_AUTO_RETRY_EN, FAULT SHALL exit only on cmd_start or cmd_stop; no retry counter SHALL exist.

Structure
REQ-028 State encoding localparams and the state_o width SHALL live in shared package detector_pkg.
REQ-029 Vsync synchronizer plus edge detect SHALL be sub-module detector_edge_sync; FSM and counters stay in the top.

Verification (RST_HOLD_CYCLES=8, SETTLE_FRAMES=2, TIMEOUT_CYCLES=100)
REQ-030 cmd_start, cfg_i2cad=1, vsync every 50 cycles -> dd_i2cad=1 next cycle, dd_nrst low 8 cycles, RUN after 2nd edge, output_select=1, frame_cnt counts 1,2,3.
REQ-031 Reaching RUN, then vsync stopped -> FAULT 100 cycles after last edge, output_select=0, dd_nrst=0, err_timeout=1; err_clr -> 0.
REQ-032 cmd_start and cmd_stop same cycle in IDLE -> stays IDLE; cmd_stop in SETTLE -> IDLE, dd_nrst=0 next cycle.
REQ-033 rst_n asserted in SETTLE -> all outputs at reset values asynchronously; no activity after release until cmd_start.
REQ-034 With DETSEQ_AUTO_RETRY_EN, no vsync ever -> exactly 3 automatic RST_HOLD re-entries, then FAULT held; without macro -> single FAULT held.
